// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with a programmable limit, wrap/saturate/one-shot
// modes, a registered terminal-count pulse and output-enable gating of the count bus.
module param_updown_counter #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             limit_wr,
   input  logic [WIDTH-1:0] limit_val,
   input  logic             start,
   input  logic             oe,
   output logic [WIDTH-1:0] count_q,
   output logic [WIDTH-1:0] count_out,
   output logic [WIDTH-1:0] count_oe,
   output logic             tc,
   output logic             busy
);

   // state | meaning
   // IDLE  | one-shot armed, count held
   // RUN   | one-shot counting towards the terminal value
   // DONE  | one-shot reached terminal value, count held
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] limit_q;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] step_val;
   logic             mode_os;
   logic             mode_sat;
   logic             mode_wrap;
   logic             load_ok;
   logic             start_ok;
   logic             step_ok;
   logic             hit;
   logic             tc_set;

   assign mode_os   = (mode == 2'b10);
   assign mode_sat  = (mode == 2'b01);
   assign mode_wrap = ~mode_os & ~mode_sat;

   // Load outranks start, start outranks a counting step.
   assign load_ok  = load & ~oe;
   assign start_ok = mode_os & start & (state_q != S_RUN) & ~load_ok;
   assign step_ok  = en & ~load_ok & ~start_ok & (~mode_os | (state_q == S_RUN));

   assign term = dir ? ZERO : limit_q;

   always_comb begin
      step_val = count_q;
      if (!dir) begin
         if (count_q >= limit_q)
            step_val = mode_wrap ? ZERO : limit_q;
         else
            step_val = count_q + ONE;
      end else begin
         if (count_q == ZERO)
            step_val = mode_wrap ? limit_q : ZERO;
         else
            step_val = count_q - ONE;
      end
   end

   assign hit = (step_val == term);

   // Saturate re-pulses only when arriving at T from elsewhere; one-shot checks the result alone.
   always_comb begin
      tc_set = 1'b0;
      if (step_ok && hit) begin
         if (mode_sat)
            tc_set = (count_q != term);
         else
            tc_set = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!mode_os) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (step_ok && hit) state_d = S_DONE;
            S_DONE:  if (start_ok) state_d = S_RUN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q == S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         limit_q <= LIMIT_RST;
         tc      <= 1'b0;
      end else begin
         if (load_ok)
            count_q <= load_val;
         else if (start_ok)
            count_q <= dir ? limit_q : ZERO;
         else if (step_ok)
            count_q <= step_val;
         if (limit_wr)
            limit_q <= limit_val;
         tc <= tc_set;
      end
   end

   assign count_out = oe ? count_q : ZERO;
   assign count_oe  = {WIDTH{oe}};

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter (WIDTH=8).
module tb_param_updown_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       dir;
   logic [1:0] mode;
   logic       load;
   logic [7:0] load_val;
   logic       limit_wr;
   logic [7:0] limit_val;
   logic       start;
   logic       oe;
   logic [7:0] count_q;
   logic [7:0] count_out;
   logic [7:0] count_oe;
   logic       tc;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   param_updown_counter #(.WIDTH(8), .LIMIT_RST(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode),
      .load(load), .load_val(load_val), .limit_wr(limit_wr), .limit_val(limit_val),
      .start(start), .oe(oe), .count_q(count_q), .count_out(count_out),
      .count_oe(count_oe), .tc(tc), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; dir = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
      limit_wr = 1'b0; limit_val = '0; start = 1'b0; oe = 1'b0;
      tick();
      vectors++;
      if (count_q !== 8'h00 || tc !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: count_q=%h tc=%b busy=%b, wanted 00 0 0", count_q, tc, busy);
      end
      vectors++;
      if (count_out !== 8'h00 || count_oe !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_bus: count_out=%h count_oe=%h, wanted 00 00", count_out, count_oe);
      end
      oe = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic test_wrap();
      logic [7:0] exp_c [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
      logic       exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      en = 1'b0; limit_wr = 1'b1; limit_val = 8'd5;
      tick();
      limit_wr = 1'b0; en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         vectors++;
         if (count_q !== exp_c[i] || tc !== exp_t[i]) begin
            miscompares++;
            $display("FAIL wrap_step%0d: count_q=%h tc=%b, wanted %h %b", i, count_q, tc, exp_c[i], exp_t[i]);
         end
      end
   endtask

   task automatic test_saturate();
      logic [7:0] exp_c [6] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
      logic       exp_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      mode = 2'b01; dir = 1'b1; en = 1'b1; oe = 1'b0; load = 1'b1; load_val = 8'd3;
      for (int i = 0; i < 6; i++) begin
         tick();
         load = 1'b0; oe = 1'b1;
         vectors++;
         if (count_q !== exp_c[i] || tc !== exp_t[i]) begin
            miscompares++;
            $display("FAIL sat_down%0d: count_q=%h tc=%b, wanted %h %b", i, count_q, tc, exp_c[i], exp_t[i]);
         end
      end
      load = 1'b1; load_val = 8'd9;
      tick();
      vectors++;
      if (count_q !== 8'd0 || tc !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_load_oe1: count_q=%h tc=%b, wanted 00 0", count_q, tc);
      end
      oe = 1'b0; dir = 1'b0;
      tick();
      load = 1'b0; oe = 1'b1;
      tick();
      vectors++;
      if (count_q !== 8'd5 || tc !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_clamp: count_q=%h tc=%b, wanted 05 1", count_q, tc);
      end
      tick();
      vectors++;
      if (count_q !== 8'd5 || tc !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_hold: count_q=%h tc=%b, wanted 05 0", count_q, tc);
      end
   endtask

   task automatic test_oneshot();
      logic [7:0] exp_c [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
      logic       exp_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       exp_b [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      mode = 2'b10; dir = 1'b0; en = 1'b1; limit_wr = 1'b1; limit_val = 8'd4;
      tick();
      limit_wr = 1'b0;
      vectors++;
      if (count_q !== 8'd5 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL os_idle_hold: count_q=%h busy=%b, wanted 05 0", count_q, busy);
      end
      en = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; en = 1'b1;
      vectors++;
      if (count_q !== 8'd0 || busy !== 1'b1 || tc !== 1'b0) begin
         miscompares++;
         $display("FAIL os_start: count_q=%h busy=%b tc=%b, wanted 00 1 0", count_q, busy, tc);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if (count_q !== exp_c[i] || tc !== exp_t[i] || busy !== exp_b[i]) begin
            miscompares++;
            $display("FAIL os_run%0d: count_q=%h tc=%b busy=%b, wanted %h %b %b",
                     i, count_q, tc, busy, exp_c[i], exp_t[i], exp_b[i]);
         end
      end
      start = 1'b1; en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (count_q !== 8'd1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL os_restart: count_q=%h busy=%b, wanted 01 1", count_q, busy);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (count_q !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: count_q=%h tc=%b busy=%b, wanted 00 0 0", count_q, tc, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mode = 2'b00; dir = 1'b0; oe = 1'b0; load = 1'b1; load_val = 8'hFE; en = 1'b1;
      tick();
      load = 1'b0; oe = 1'b1;
      tick();
      vectors++;
      if (count_q !== 8'hFF || tc !== 1'b1) begin
         miscompares++;
         $display("FAIL limit_after_reset: count_q=%h tc=%b, wanted ff 1", count_q, tc);
      end
      tick();
      vectors++;
      if (count_q !== 8'h00 || tc !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_ff: count_q=%h tc=%b, wanted 00 0", count_q, tc);
      end
   endtask

   task automatic test_down_wrap();
      logic [7:0] exp_c [6] = '{8'hFF, 8'hFE, 8'h02, 8'h01, 8'h00, 8'hFF};
      logic       exp_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      dir = 1'b1; en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin
            oe = 1'b0; load = 1'b1; load_val = 8'h02;
         end
         tick();
         load = 1'b0; oe = 1'b1;
         vectors++;
         if (count_q !== exp_c[i] || tc !== exp_t[i]) begin
            miscompares++;
            $display("FAIL down_wrap%0d: count_q=%h tc=%b, wanted %h %b", i, count_q, tc, exp_c[i], exp_t[i]);
         end
      end
      dir = 1'b0; oe = 1'b0; load = 1'b1; load_val = 8'h7F;
      tick();
      load = 1'b0; oe = 1'b1; limit_wr = 1'b1; limit_val = 8'h10;
      tick();
      limit_wr = 1'b0;
      vectors++;
      if (count_q !== 8'h80) begin
         miscompares++;
         $display("FAIL limit_wr_edge: count_q=%h, wanted 80", count_q);
      end
      tick();
      vectors++;
      if (count_q !== 8'h00) begin
         miscompares++;
         $display("FAIL limit_lowered_wrap: count_q=%h, wanted 00", count_q);
      end
   endtask

   task automatic test_oe();
      en = 1'b0; oe = 1'b0; load = 1'b1; load_val = 8'h2A;
      tick();
      load = 1'b0;
      vectors++;
      if (count_q !== 8'h2A || count_out !== 8'h00 || count_oe !== 8'h00) begin
         miscompares++;
         $display("FAIL oe_low: count_q=%h count_out=%h count_oe=%h, wanted 2a 00 00", count_q, count_out, count_oe);
      end
      oe = 1'b1;
      #1;
      vectors++;
      if (count_out !== 8'h2A || count_oe !== 8'hFF) begin
         miscompares++;
         $display("FAIL oe_high: count_out=%h count_oe=%h, wanted 2a ff", count_out, count_oe);
      end
   endtask

   task automatic test_back_to_back();
      mode = 2'b00; dir = 1'b0; limit_wr = 1'b1; limit_val = 8'h00; en = 1'b0;
      tick();
      limit_wr = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (count_q !== 8'h00 || tc !== 1'b1) begin
            miscompares++;
            $display("FAIL limit0_%0d: count_q=%h tc=%b, wanted 00 1", i, count_q, tc);
         end
      end
      mode = 2'b10; limit_wr = 1'b1; limit_val = 8'h03; start = 1'b1; en = 1'b0;
      tick();
      limit_wr = 1'b0; start = 1'b0; mode = 2'b00;
      tick();
      vectors++;
      if (busy !== 1'b0 || count_q !== 8'h00) begin
         miscompares++;
         $display("FAIL mode_exit: busy=%b count_q=%h, wanted 0 00", busy, count_q);
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_saturate();
      test_oneshot();
      test_async_reset();
      test_down_wrap();
      test_oe();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
